// File: rtl/matmul_arbiter.sv
// Round-robin arbiter granting one shared matmul engine to one of NUM_REQ requesters.
// Latency: req in IDLE -> grant/mm_start next cycle; mm_done -> req_done next cycle, IDLE one after.
// Backpressure: requesters hold req until req_done; a hung engine is released after TIMEOUT_CYCLES.
module matmul_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SEL_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mm_done,
  input  logic               err_clr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               mm_start,
  output logic [NUM_REQ-1:0] req_done,
  output logic               busy,
  output logic               timeout_err
);

  // Counter is one bit wider than strictly needed so the terminal increment never aliases.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       rr_ptr;
  logic [SEL_W-1:0]       pick;
  logic                   pick_vld;
  logic [CNT_W-1:0]       cnt;
  logic                   timeout_hit;
  logic [NUM_REQ-1:0]     sel_oh;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic [SEL_W:0]         pick_sum;

  assign sel_oh      = NUM_REQ'(1) << sel;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign req_dbl     = {req, req} >> rr_ptr;
  assign req_rot     = req_dbl[NUM_REQ-1:0];

  // Circular first-set search starting at rr_ptr: rotate, find lowest bit, add offset back.
  always_comb begin
    pick_vld = 1'b0;
    pick_sum = {1'b0, rr_ptr};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_rot[i]) begin
        pick_vld = 1'b1;
        pick_sum = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      end
    end
    if (pick_sum >= (SEL_W+1)'(NUM_REQ)) begin
      pick_sum = pick_sum - (SEL_W+1)'(NUM_REQ);
    end
    pick = pick_sum[SEL_W-1:0];
  end

  // State register; reset aborts any transaction without a completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore-decoded outputs; grant only while the engine is owned.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    mm_start  = 1'b0;
    req_done  = '0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        grant     = sel_oh;
        mm_start  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        grant = sel_oh;
        if (mm_done || timeout_hit) state_nxt = RELEASE;
      end
      RELEASE: begin
        req_done  = sel_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner index latched at grant time and held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        sel <= '0;
    else if (state == IDLE && pick_vld) sel <= pick;
  end

  // Round-robin pointer moves just past the owner whenever a grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == RELEASE) begin
      rr_ptr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
    end
  end

  // BUSY cycle counter, cleared on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == ISSUE) cnt <= '0;
    else if (state == BUSY)  cnt <= cnt + CNT_W'(1);
  end

  // Sticky timeout flag; a simultaneous set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         timeout_err <= 1'b0;
    else if (state == BUSY && timeout_hit && !mm_done) timeout_err <= 1'b1;
    else if (err_clr)                                timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed bench for matmul_arbiter: fairness, single request, spurious done, timeout, reset abort.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
// Engine model is the bench itself: mm_done is driven by hand at chosen cycles.
module tb_matmul_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mm_done;
  logic       err_clr;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       mm_start;
  logic [3:0] req_done;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int w;
  int order [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  matmul_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .mm_done(mm_done), .err_clr(err_clr),
    .grant(grant), .sel(sel), .mm_start(mm_start), .req_done(req_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    while (mm_start !== 1'b1 && waited < 30) begin
      cyc();
      waited++;
    end
    chk("start_seen", mm_start, 1);
  endtask

  // One fairness transaction: expect owner exp_idx, complete after dly BUSY cycles,
  // then drop the owner's req for one cycle and re-raise it.
  task automatic run_txn(input int exp_idx, input int dly, output int waited);
    wait_start(waited);
    chk("fair_sel", sel, exp_idx);
    chk("fair_grant", grant, 32'd1 << exp_idx);
    repeat (dly) cyc();
    mm_done = 1'b1;
    cyc();
    mm_done = 1'b0;
    chk("fair_done", req_done, 32'd1 << exp_idx);
    req[exp_idx] = 1'b0;
    cyc();
    req[exp_idx] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req = '0; mm_done = 1'b0; err_clr = 1'b0;
    repeat (2) cyc();
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_start", mm_start, 0);
    chk("rst_done", req_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    cyc();

    // Fairness: all four requesting, order 0,1,2,3,0 with back-to-back grants at k+3.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_txn(order[n], 2 + n, w);
      if (n > 0) chk("fair_gap", w, 1);
    end
    req = '0;
    cyc();
    chk("fair_idle", busy, 0);

    // Single request on index 2; owner drop and non-owner changes mid-BUSY are ignored.
    req = 4'b0100;                 // cycle 0
    cyc();                         // cycle 1
    chk("s_grant", grant, 4'b0100);
    chk("s_sel", sel, 2);
    chk("s_start", mm_start, 1);
    chk("s_busy", busy, 1);
    cyc();                         // cycle 2
    chk("s_start_pulse", mm_start, 0);
    repeat (3) cyc();              // cycle 5
    req = 4'b1011;
    cyc();                         // cycle 6
    chk("s_grant_held", grant, 4'b0100);
    req = 4'b0000;
    repeat (4) cyc();              // cycle 10
    mm_done = 1'b1;
    cyc();                         // cycle 11
    mm_done = 1'b0;
    chk("s_req_done", req_done, 4'b0100);
    chk("s_grant_rel", grant, 0);
    chk("s_busy_rel", busy, 1);
    cyc();                         // cycle 12
    chk("s_busy_idle", busy, 0);
    chk("s_sel_hold", sel, 2);
    chk("s_done_once", req_done, 0);

    // Spurious mm_done in IDLE and ISSUE.
    mm_done = 1'b1;
    cyc();
    chk("sp_idle_busy", busy, 0);
    chk("sp_idle_done", req_done, 0);
    mm_done = 1'b0;
    req = 4'b0001;
    cyc();
    chk("sp_start", mm_start, 1);
    chk("sp_grant", grant, 4'b0001);
    mm_done = 1'b1;
    cyc();
    chk("sp_issue_busy", busy, 1);
    chk("sp_issue_done", req_done, 0);
    chk("sp_issue_grant", grant, 4'b0001);
    mm_done = 1'b0;
    cyc();
    mm_done = 1'b1;
    cyc();
    chk("sp_real_done", req_done, 4'b0001);
    mm_done = 1'b0;
    req = '0;
    cyc();
    chk("sp_idle_after", busy, 0);

    // Timeout on requester 1 with TIMEOUT_CYCLES=16.
    req = 4'b0010;
    cyc();
    chk("to_grant", grant, 4'b0010);
    cyc();                         // first BUSY cycle
    repeat (15) cyc();
    chk("to_early_done", req_done, 0);
    chk("to_early_err", timeout_err, 0);
    chk("to_early_busy", busy, 1);
    cyc();                         // 16 cycles after BUSY entry
    chk("to_err", timeout_err, 1);
    chk("to_req_done", req_done, 4'b0010);
    chk("to_grant_rel", grant, 0);
    req = '0;
    err_clr = 1'b1;
    cyc();
    chk("to_clr", timeout_err, 0);
    err_clr = 1'b0;

    // err_clr coinciding with a timeout: set wins.
    req = 4'b0100;
    cyc();
    chk("tc_grant", grant, 4'b0100);
    cyc();
    repeat (15) cyc();
    err_clr = 1'b1;
    cyc();
    chk("tc_err", timeout_err, 1);
    chk("tc_req_done", req_done, 4'b0100);
    err_clr = 1'b0;
    req = '0;
    cyc();

    // Reset mid-BUSY with owner 3.
    req = 4'b1000;
    cyc();
    chk("rb_sel", sel, 3);
    cyc();
    cyc();
    chk("rb_grant", grant, 4'b1000);
    rst = 1'b1;
    #1;
    chk("rb_grant0", grant, 0);
    chk("rb_sel0", sel, 0);
    chk("rb_start0", mm_start, 0);
    chk("rb_busy0", busy, 0);
    chk("rb_terr0", timeout_err, 0);
    cyc();
    chk("rb_done0", req_done, 0);
    req = 4'b1001;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rb_first_grant", grant, 4'b0001);
    chk("rb_first_sel", sel, 0);
    chk("rb_first_start", mm_start, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_arbiter.md
MATMUL_ARBITER -- requirements
Module: matmul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one matmul engine (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum BUSY cycles before the grant is forcibly released.
REQ-003 Parameter SEL_W, default $clog2(NUM_REQ), width of the owner index.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  level request per requester; requester holds it until its req_done pulse.
REQ-007 mm_done  input  1  engine completion pulse.
REQ-008 err_clr  input  1  clears timeout_err.
REQ-009 grant  output  NUM_REQ  one-hot owner; drives the engine input mux and the result-capture enable.
REQ-010 sel  output  SEL_W  binary index of the current or last owner.
REQ-011 mm_start  output  1  one-cycle engine start pulse.
REQ-012 req_done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 timeout_err  output  1  sticky timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, BUSY and RELEASE; all outputs SHALL be registered or Moore-decoded from state.
REQ-016 IDLE: when any req bit is set, select the first set bit searching upward circularly from rr_ptr; register grant and sel; go to ISSUE. With no request, stay in IDLE.
REQ-017 ISSUE: mm_start=1 for exactly one cycle; clear the cycle counter; go to BUSY; mm_done is ignored in this state.
REQ-018 BUSY: increment the counter each cycle; if mm_done=1, go to RELEASE.
REQ-019 BUSY: if the counter reaches TIMEOUT_CYCLES-1 without mm_done, set timeout_err and go to RELEASE.
REQ-020 grant SHALL be non-zero and one-hot only in ISSUE and BUSY, and all-zero otherwise.
REQ-021 RELEASE: req_done[sel]=1 for one cycle, for both normal completion and timeout; set rr_ptr=(sel+1) mod NUM_REQ; go to IDLE.
REQ-022 Latency: req sampled in IDLE at cycle t gives grant and mm_start at t+1; mm_done sampled at cycle k gives req_done at k+1 and IDLE at k+2.
REQ-023 The earliest next grant after a completion SHALL be at k+3.
REQ-024 A req bit still high in IDLE after its req_done SHALL be treated as a new request.
REQ-025 Deassertion of the owner's req during ISSUE or BUSY SHALL be ignored; the transaction runs to completion.
REQ-026 mm_done in IDLE, ISSUE or RELEASE SHALL be ignored and SHALL NOT pulse req_done.
REQ-027 Changes to non-owner req bits SHALL NOT affect an in-flight grant.
REQ-028 If err_clr and a timeout set occur in the same cycle, set wins.
REQ-029 sel SHALL hold its value through RELEASE and IDLE until the next grant.

Reset
REQ-030 While rst=1: state=IDLE, grant=0, sel=0, mm_start=0, req_done=0, busy=0, timeout_err=0, rr_ptr=0, counter=0.
REQ-031 Reset asserted in any state SHALL abort the transaction immediately with no req_done pulse; the first arbitration after reset starts from index 0.

Verification
REQ-032 Single request: req=4'b0100 at cycle 0 -> grant=4'b0100, sel=2, mm_start pulse at cycle 1; mm_done at cycle 10 -> req_done=4'b0100 at 11, busy=0 at 12.
REQ-033 Fairness: req=4'b1111 held, each requester dropping its req after its req_done and re-raising it next cycle -> grant order 0,1,2,3,0; no requester granted twice before all others.
REQ-034 Timeout (TIMEOUT_CYCLES=16): grant 1, mm_done never asserted -> timeout_err=1 and req_done=4'b0010 exactly 16 cycles after BUSY entry; err_clr=1 clears it the next cycle.
REQ-035 Spurious mm_done in IDLE and in ISSUE -> no state change and no req_done; the real mm_done in BUSY completes normally.
REQ-036 rst pulsed mid-BUSY with owner 3 -> all outputs 0 while rst=1; after release with req=4'b1001, the first grant is 4'b0001.
REQ-037 err_clr and timeout in the same cycle -> timeout_err=1 afterwards.
